// File: rtl/fb_pixel_writer.sv
// Packs an 8-bit RRRGGGBB pixel stream two-per-word and writes the words
// row-major into port A of the 16K x 16 frame memory, framed by start-of-frame.
module fb_pixel_writer #(
   parameter int unsigned COLS        = 160,
   parameter int unsigned ROWS        = 120,
   parameter logic [13:0] BASE_ADDR   = 14'd0,
   parameter bit          GATE_VBLANK = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pix_data,
   input  logic        pix_valid,
   input  logic        pix_sof,
   output logic        pix_ready,
   input  logic        vblank,
   output logic        mem_we,
   output logic [13:0] mem_addr,
   output logic [15:0] mem_din,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic        sync_err
);

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned PIX_W  = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned COL_W  = (COLS > 2) ? $clog2(COLS) : 1;
   localparam int unsigned ROW_W  = (ROWS > 2) ? $clog2(ROWS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   word_q, word_d;
   logic [PIX_W-1:0]    low_q, low_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0]   mem_din_q, mem_din_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic [CNT_W-1:0]    frame_count_q, frame_count_d;
   logic                sync_err_q, sync_err_d;
   logic                accept;

   // Ready is combinational so a gated or DONE cycle stalls the source immediately
   assign pix_ready = (GATE_VBLANK ? vblank : 1'b1) && (state_q != ST_DONE);
   assign accept    = pix_valid && pix_ready;

   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      word_d        = word_q;
      low_d         = low_q;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_din_d     = mem_din_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      sync_err_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (pix_sof) begin
                  low_d   = pix_data;
                  col_d   = COL_W'(1);
                  row_d   = '0;
                  word_d  = '0;
                  state_d = ST_ACTIVE;
               end else begin
                  sync_err_d = 1'b1;
               end
            end
         end
         ST_ACTIVE: begin
            if (accept) begin
               if (pix_sof) begin
                  // Resynchronise: this pixel becomes (0,0); any held low byte is lost
                  sync_err_d = 1'b1;
                  low_d      = pix_data;
                  col_d      = COL_W'(1);
                  row_d      = '0;
                  word_d     = '0;
               end else begin
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     row_d = row_q + ROW_W'(1);
                  end else begin
                     col_d = col_q + COL_W'(1);
                  end
                  if (!col_q[0]) begin
                     low_d = pix_data;
                  end else begin
                     mem_we_d   = 1'b1;
                     mem_addr_d = BASE_ADDR + word_q;
                     mem_din_d  = {pix_data, low_q};
                     word_d     = word_q + ADDR_W'(1);
                     if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                        row_d   = '0;
                        state_d = ST_DONE;
                     end
                  end
               end
            end
         end
         ST_DONE: begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + CNT_W'(1);
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         col_q         <= '0;
         row_q         <= '0;
         word_q        <= '0;
         low_q         <= '0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= BASE_ADDR;
         mem_din_q     <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         word_q        <= word_d;
         low_q         <= low_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_din_q     <= mem_din_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_din     = mem_din_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign sync_err    = sync_err_q;

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side counterpart to the VGA pixel fetch path.
- Accepts a stream of 8-bit RRRGGGBB pixels with a valid/ready handshake and packs two pixels per 16-bit word.
- Writes each word into port A of the 16K x 16 frame memory (we/addr/din), in row-major order.
- Frame starts are delimited by a start-of-frame flag. Optionally, writes are gated to vertical blanking so the display never shows a partially written frame.

Parameters:
- COLS, 160, pixels per row; must be even.
- ROWS, 120, rows per frame; (COLS/2)*ROWS must be <= 16384.
- BASE_ADDR, 14'd0, word address of pixel (0,0).
- GATE_VBLANK, 0. When 1, pixels are accepted only while vblank is high.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_data  in  8  pixel, {R[2:0],G[2:0],B[1:0]}.
- pix_valid  in  1  pix_data valid.
- pix_sof  in  1  qualifies pix_data as pixel (0,0) of a frame; meaningful only with pix_valid.
- pix_ready  out  1  block accepts pixel this cycle.
- vblank  in  1  display in vertical blanking; used only when GATE_VBLANK=1.
- mem_we  out  1  write strobe to memory port A.
- mem_addr  out  14  word address.
- mem_din  out  16  write data; bits [7:0] = even-column pixel, bits [15:8] = odd-column pixel.
- busy  out  1  frame in progress (state ACTIVE).
- frame_done  out  1  one-cycle pulse after the last word of a frame is written.
- frame_count  out  8  completed frames; wraps 255 -> 0.
- sync_err  out  1  one-cycle pulse on a dropped pixel or a mid-frame SOF.

Behaviour:
- Handshake: a pixel is accepted when pix_valid && pix_ready are both high at a rising edge.
- pix_ready is combinational: it equals (GATE_VBLANK ? vblank : 1) && state != DONE.
- Reset (async, rst_n=0) forces:
  - mem_we=0, mem_addr=BASE_ADDR, mem_din=0;
  - busy=0, frame_done=0, frame_count=0, sync_err=0;
  - state=IDLE, col=0, row=0, word counter=0, low-byte holding register=0.
- States:
  - IDLE:
    - Accepted pixel with pix_sof=1: store it as the low byte, set col=1, go to ACTIVE.
    - Accepted pixel with pix_sof=0: drop it and pulse sync_err for one cycle.
  - ACTIVE:
    - Even col: store the pixel in the low byte.
    - Odd col: register the write. Next cycle, mem_we=1, mem_din={pixel, low byte}, mem_addr=BASE_ADDR+word counter. The word counter then increments.
    - col counts 0..COLS-1 and wraps to 0 with row+1.
    - Acceptance of pixel (COLS-1, ROWS-1): the final write is registered and state goes to DONE.
  - DONE (one cycle, pix_ready=0): mem_we=1 for the last word; frame_done=1 on the following cycle; frame_count increments; state returns to IDLE.
- Latency: an odd-column pixel accepted at edge N gives mem_we=1 during cycle N+1. mem_we is high for exactly one cycle per word.
- Throughput: one pixel per cycle; no back-pressure in ACTIVE apart from the vblank gate.
- mem_addr and mem_din hold their last values when mem_we=0.
- Mid-frame SOF (accepted in ACTIVE with pix_sof=1):
  - pulse sync_err;
  - discard any held low byte; no partial word is written;
  - reset col, row and the word counter to 0;
  - treat this pixel as pixel (0,0) and stay in ACTIVE.
  - A word write already registered from the previous edge still completes.
- Vblank gate: when vblank falls mid-frame with GATE_VBLANK=1, pix_ready drops. State and counters hold; the frame resumes at the next vblank.
- Address arithmetic: BASE_ADDR + word counter, 14-bit, wraps modulo 16384. Exceeding the memory is a configuration error and is not checked.
- The block never reads memory. The display path owns the read port independently.

Test Plan:
- Basic fill: COLS=4, ROWS=2, GATE_VBLANK=0. Stream 8 pixels 0x01..0x08 back-to-back, SOF on 0x01. Required result:
  - writes addr0=0x0201, addr1=0x0403, addr2=0x0605, addr3=0x0807;
  - each write one cycle after its odd pixel;
  - frame_done one cycle after the last write;
  - frame_count=1; pix_ready=0 for exactly the DONE cycle.
- IDLE drop: send 0xAA without SOF, then a full frame. Required result: 0xAA is dropped, sync_err pulses once, and the frame is written at addr0..3 unchanged.
- Mid-frame SOF: send 0x11, 0x22, 0x33, then 0x44 with SOF, then 7 more pixels. Required result:
  - word 0x2211 written to addr0;
  - 0x33 discarded and sync_err=1;
  - the next writes restart at addr0 with low byte 0x44.
- Vblank gating: GATE_VBLANK=1, vblank=0 with pix_valid high. Required result: pix_ready=0 and no writes. Raising vblank resumes acceptance; drop vblank after pixel 3; the frame completes correctly after vblank returns.
- Reset mid-frame: assert rst_n=0 asynchronously after 5 pixels. Required result: mem_we=0 immediately, all outputs at reset values, and the next SOF frame writes from addr0.
- Counter wrap: run 256 frames. Required result: frame_count returns to 0 and frame_done pulses 256 times.
